// File: rtl/request_latch_arbiter_if.sv
// Bundle between the request latch/grant sequencer, its priority encoder and the grant consumer.
interface request_latch_arbiter_if #(
   parameter int CNT_W = 8
);
   logic [3:0]       req;
   logic [2:0]       enc_code;
   logic             gnt_ready;
   logic [3:0]       pend;
   logic             gnt_valid;
   logic [1:0]       gnt_idx;
   logic [3:0]       gnt_onehot;
   logic             busy;
   logic [CNT_W-1:0] grant_count;
   logic             code_err;

   modport master (
      output req, enc_code, gnt_ready,
      input  pend, gnt_valid, gnt_idx, gnt_onehot, busy, grant_count, code_err
   );

   modport slave (
      input  req, enc_code, gnt_ready,
      output pend, gnt_valid, gnt_idx, gnt_onehot, busy, grant_count, code_err
   );
endinterface

// File: rtl/request_latch_arbiter.sv
// Sticky request latch feeding an external priority encoder, and a one-at-a-time
// grant sequencer (IDLE -> GRANT -> CLEAR) driven by the returned encoder code.
module request_latch_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic                    Clock,
   input  logic                    Resetn,
   request_latch_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

   state_t           state_reg, state_next;
   logic [1:0]       gnt_idx_reg, gnt_idx_next;
   logic [3:0]       pend_reg;
   logic [CNT_W-1:0] count_reg;
   logic             code_err_reg, code_err_next;
   logic [3:0]       clr_mask;
   logic [3:0]       onehot;
   logic             gnt_valid;

   assign gnt_valid = (state_reg == GRANT);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_decode
         assign clr_mask[gi] = (state_reg == CLEAR) && (gnt_idx_reg == 2'(gi));
         assign onehot[gi]   = gnt_valid && (gnt_idx_reg == 2'(gi));
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      gnt_idx_next  = gnt_idx_reg;
      code_err_next = code_err_reg;
      case (state_reg)
         IDLE: begin
            if (bus.enc_code >= 3'd1 && bus.enc_code <= 3'd4) begin
               gnt_idx_next = 2'(bus.enc_code - 3'd1);
               state_next   = GRANT;
            end else if (bus.enc_code >= 3'd5) begin
               code_err_next = 1'b1;
            end
         end
         GRANT: begin
            if (bus.gnt_ready) state_next = CLEAR;
         end
         CLEAR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A request landing in the same cycle as its clear keeps the bit set.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_reg    <= IDLE;
         gnt_idx_reg  <= 2'd0;
         pend_reg     <= 4'd0;
         count_reg    <= '0;
         code_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         gnt_idx_reg  <= gnt_idx_next;
         pend_reg     <= (pend_reg & ~clr_mask) | bus.req;
         code_err_reg <= code_err_next;
         if (state_reg == CLEAR) count_reg <= count_reg + 1'b1;
      end
   end

   assign bus.pend        = pend_reg;
   assign bus.gnt_valid   = gnt_valid;
   assign bus.gnt_idx     = gnt_idx_reg;
   assign bus.gnt_onehot  = onehot;
   assign bus.busy        = (state_reg != IDLE);
   assign bus.grant_count = count_reg;
   assign bus.code_err    = code_err_reg;
endmodule

// File: tb/tb_request_latch_arbiter.sv
// Randomised and directed bench: behavioural grant model compared every cycle,
// plus literal expectations for the key scenarios.
module tb_request_latch_arbiter;
   localparam int CNT_W = 2;

   logic clk;
   logic resetn;
   logic force_en;
   logic [2:0] force_val;
   int errors = 0;
   int checks = 0;
   logic cmp_en = 1'b0;

   request_latch_arbiter_if #(.CNT_W(CNT_W)) bus ();

   request_latch_arbiter #(.CNT_W(CNT_W)) dut (
      .Clock  (clk),
      .Resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side priority encoder: highest set bit wins, code = index+1.
   function automatic logic [2:0] prio(input logic [3:0] p);
      for (int i = 3; i >= 0; i--) if (p[i]) return 3'(i + 1);
      return 3'd0;
   endfunction

   assign bus.enc_code = force_en ? force_val : prio(bus.pend);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a grant is either absent, being offered, or being retired.
   logic [3:0] m_pend;
   logic       m_offering;
   logic       m_retiring;
   int         m_idx;
   int         m_count;
   logic       m_err;

   always @(posedge clk) begin
      logic [3:0] cleared;
      int code;
      if (!resetn) begin
         m_pend = 4'd0; m_offering = 1'b0; m_retiring = 1'b0;
         m_idx = 0; m_count = 0; m_err = 1'b0;
      end else begin
         cleared = m_retiring ? 4'(1 << m_idx) : 4'd0;
         code = force_en ? int'(force_val) : int'(prio(m_pend));
         if (m_retiring) begin
            m_retiring = 1'b0;
            m_count++;
         end else if (m_offering) begin
            if (bus.gnt_ready) begin
               m_offering = 1'b0;
               m_retiring = 1'b1;
            end
         end else if (code >= 1 && code <= 4) begin
            m_idx = code - 1;
            m_offering = 1'b1;
         end else if (code >= 5) begin
            m_err = 1'b1;
         end
         m_pend = (m_pend & ~cleared) | bus.req;
      end
   end

   // Transfer log: one line per completed handshake.
   int xfer_q[$];
   always @(posedge clk) begin
      if (resetn && bus.gnt_valid && bus.gnt_ready) begin
         xfer_q.push_back(int'(bus.gnt_idx));
         $display("grant idx=%0d count_before=%0d t=%0t", bus.gnt_idx, bus.grant_count, $time);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("pend", 32'(bus.pend), 32'(m_pend));
         check("gnt_valid", 32'(bus.gnt_valid), 32'(m_offering));
         check("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
         check("gnt_onehot", 32'(bus.gnt_onehot), m_offering ? 32'(1 << m_idx) : 32'd0);
         check("busy", 32'(bus.busy), 32'(m_offering | m_retiring));
         check("grant_count", 32'(bus.grant_count), 32'(m_count % (1 << CNT_W)));
         check("code_err", 32'(bus.code_err), 32'(m_err));
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(2);
      resetn = 1'b1;
      xfer_q.delete();
   endtask

   initial begin
      resetn = 1'b0;
      force_en = 1'b0;
      force_val = 3'd0;
      bus.req = 4'd0;
      bus.gnt_ready = 1'b0;

      // Reset with all requests asserted: they must be ignored.
      @(negedge clk);
      bus.req = 4'b1111;
      step(2);
      cmp_en = 1'b1;
      check("rst_pend", 32'(bus.pend), 32'd0);
      check("rst_valid", 32'(bus.gnt_valid), 32'd0);
      check("rst_count", 32'(bus.grant_count), 32'd0);
      check("rst_err", 32'(bus.code_err), 32'd0);
      bus.req = 4'd0;
      resetn = 1'b1;
      xfer_q.delete();

      // Single request with ready held high.
      bus.gnt_ready = 1'b1;
      bus.req = 4'b0010;
      step(1);
      bus.req = 4'd0;
      check("single_pend_set", 32'(bus.pend), 32'h2);
      check("single_valid_early", 32'(bus.gnt_valid), 32'd0);
      step(1);
      check("single_valid", 32'(bus.gnt_valid), 32'd1);
      check("single_idx", 32'(bus.gnt_idx), 32'd1);
      check("single_onehot", 32'(bus.gnt_onehot), 32'h2);
      step(2);
      check("single_pend_clr", 32'(bus.pend), 32'd0);
      check("single_count", 32'(bus.grant_count), 32'd1);

      // Priority with a higher request injected during the first grant.
      do_reset();
      bus.req = 4'b0101;
      step(1);
      bus.req = 4'd0;
      step(1);
      check("prio_first_idx", 32'(bus.gnt_idx), 32'd2);
      bus.req = 4'b1000;
      step(1);
      bus.req = 4'd0;
      step(10);
      check("prio_n", 32'(xfer_q.size()), 32'd3);
      if (xfer_q.size() == 3) begin
         check("prio_o0", 32'(xfer_q[0]), 32'd2);
         check("prio_o1", 32'(xfer_q[1]), 32'd3);
         check("prio_o2", 32'(xfer_q[2]), 32'd0);
      end
      check("prio_count", 32'(bus.grant_count), 32'd3);

      // Backpressure: grant must hold steady while ready is low.
      do_reset();
      bus.gnt_ready = 1'b0;
      bus.req = 4'b0001;
      step(1);
      bus.req = 4'd0;
      step(1);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 32'(bus.gnt_valid), 32'd1);
         check("bp_idx", 32'(bus.gnt_idx), 32'd0);
         check("bp_count", 32'(bus.grant_count), 32'd0);
         step(1);
      end
      bus.gnt_ready = 1'b1;
      step(2);
      check("bp_xfers", 32'(xfer_q.size()), 32'd1);
      check("bp_count_after", 32'(bus.grant_count), 32'd1);

      // Same-bit set during CLEAR keeps the bit and yields a second grant.
      do_reset();
      bus.req = 4'b0001;
      step(1);
      bus.req = 4'd0;
      step(2);
      check("sb_busy_clear", 32'(bus.busy), 32'd1);
      bus.req = 4'b0001;
      step(1);
      bus.req = 4'd0;
      check("sb_pend_kept", 32'(bus.pend), 32'h1);
      check("sb_count1", 32'(bus.grant_count), 32'd1);
      step(4);
      check("sb_xfers", 32'(xfer_q.size()), 32'd2);
      check("sb_count2", 32'(bus.grant_count), 32'd2);

      // Invalid encoder code sampled in IDLE.
      do_reset();
      force_en = 1'b1;
      force_val = 3'd6;
      step(1);
      check("err_set", 32'(bus.code_err), 32'd1);
      check("err_busy", 32'(bus.busy), 32'd0);
      force_en = 1'b0;
      step(2);
      check("err_sticky", 32'(bus.code_err), 32'd1);

      // Counter wrap with a 2-bit counter: 5 grants -> 1.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.req = 4'b0100;
         step(1);
         bus.req = 4'd0;
         step(3);
      end
      check("wrap_count", 32'(bus.grant_count), 32'd1);

      // Random traffic, including mid-operation resets and bad codes.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         bus.gnt_ready = ($urandom_range(0, 2) != 0);
         force_en = ($urandom_range(0, 60) == 0);
         force_val = 3'($urandom);
         resetn = ($urandom_range(0, 250) != 0);
         step(1);
      end
      resetn = 1'b1;
      force_en = 1'b0;
      step(2);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
